// File: rtl/stack_code_loader_if.sv
// Byte-stream input and code-store write port of the stack-machine program loader.
interface stack_code_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic        run;
  logic        error;
  logic [7:0]  words_loaded;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, run, error, words_loaded
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, run, error, words_loaded
  );
endinterface

// File: rtl/stack_code_loader.sv
// Loads a length-prefixed program into the code store, then zero-fills; writes land one cycle after the HI byte.
// Backpressure via in_ready (low outside LEN/LO/HI/CSUM); STACK_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module stack_code_loader (
  input  logic               clk,
  input  logic               rst_n,
  stack_code_loader_if.slave bus
);

  typedef enum logic [2:0] {
    LEN,
    LO,
    HI,
`ifdef STACK_LOADER_CHECKSUM_EN
    CSUM,
`endif
    FILL,
    DONE,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  operand_q, operand_d;
  logic [7:0]  wl_q, wl_d;
  logic [7:0]  fill_addr_q, fill_addr_d;
  logic        word_pend_q, word_pend_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [11:0] mem_wdata_q, mem_wdata_d;
  logic        in_ready_q, in_ready_d;
  logic        run_q, run_d;
  logic        error_q, error_d;

  logic accept;
  logic hi_ok;
  logic last_word;

  assign accept    = bus.in_valid & in_ready_q;
  assign hi_ok     = (bus.in_data[7:4] == 4'd0) && (bus.in_data[3:0] <= 4'd11);
  assign last_word = ({1'b0, wl_q} + 9'd1) >= {1'b0, n_q};

`ifdef STACK_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept && (state_q == LEN || state_q == LO || state_q == HI)) begin
      csum_d = csum_q ^ bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      csum_q <= 8'd0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    operand_d   = operand_q;
    wl_d        = wl_q;
    fill_addr_d = fill_addr_q;
    word_pend_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // The count of a word advances the cycle after its write is presented.
    if (word_pend_q) begin
      wl_d = wl_q + 8'd1;
    end

    case (state_q)
      LEN: begin
        if (accept) begin
          n_d     = bus.in_data;
          state_d = (bus.in_data == 8'd0) ? ERR : LO;
        end
      end
      LO: begin
        if (accept) begin
          operand_d = bus.in_data;
          state_d   = HI;
        end
      end
      HI: begin
        if (accept) begin
          if (!hi_ok) begin
            state_d = ERR;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wl_q;
            mem_wdata_d = {operand_q, bus.in_data[3:0]};
            word_pend_d = 1'b1;
            if (last_word) begin
              fill_addr_d = n_q;
`ifdef STACK_LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = FILL;
`endif
            end else begin
              state_d = LO;
            end
          end
        end
      end
`ifdef STACK_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          state_d = (bus.in_data == csum_q) ? FILL : ERR;
        end
      end
`endif
      FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = fill_addr_q;
        mem_wdata_d = 12'h000;
        if (fill_addr_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          fill_addr_d = fill_addr_q + 8'd1;
        end
      end
      DONE: state_d = DONE;
      ERR:  state_d = ERR;
      default: state_d = ERR;
    endcase

    // Status outputs are registered from the next state so they never glitch.
    in_ready_d = (state_d == LEN) || (state_d == LO) || (state_d == HI)
`ifdef STACK_LOADER_CHECKSUM_EN
                 || (state_d == CSUM)
`endif
                 ;
    run_d   = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= LEN;
      n_q         <= 8'd0;
      operand_q   <= 8'd0;
      wl_q        <= 8'd0;
      fill_addr_q <= 8'd0;
      word_pend_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 12'd0;
      in_ready_q  <= 1'b1;
      run_q       <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      operand_q   <= operand_d;
      wl_q        <= wl_d;
      fill_addr_q <= fill_addr_d;
      word_pend_q <= word_pend_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      run_q       <= run_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.run          = run_q;
  assign bus.error        = error_q;
  assign bus.words_loaded = wl_q;

endmodule

// File: tb/tb_stack_code_loader.sv
// Directed and randomized program loads checked against a behavioural model of the loader.
module tb_stack_code_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_code_loader_if bus();
  stack_code_loader dut (.clk(clk), .rst_n(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  int test_id  = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write capture and protocol watch, cleared whenever reset is held.
  logic [11:0] cap_mem [256];
  int unsigned cap_cyc [256];
  int          cap_cnt;
  bit          mon_bad, prev_run, prev_err;
  always @(negedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) cap_mem[a] <= 12'hFFF;
      cap_cnt  <= 0;
      mon_bad  <= 1'b0;
      prev_run <= 1'b0;
      prev_err <= 1'b0;
    end else begin
      if (bus.mem_we === 1'b1) begin
        cap_mem[bus.mem_addr] <= bus.mem_wdata;
        cap_cyc[bus.mem_addr] <= cyc;
        cap_cnt <= cap_cnt + 1;
      end
      if (bus.run === 1'b1 && bus.error === 1'b1) mon_bad <= 1'b1;
      if ((prev_run && bus.run !== 1'b1) || (prev_err && bus.error !== 1'b1)) mon_bad <= 1'b1;
      if (bus.error === 1'b1 && bus.mem_we !== 1'b0) mon_bad <= 1'b1;
      prev_run <= (bus.run === 1'b1);
      prev_err <= (bus.error === 1'b1);
    end
  end

  logic [7:0]  prog [$];
  logic [11:0] exp_mem [256];
  bit          exp_err;
  int          exp_wl, exp_wcnt, exp_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL t%0d %s: observed %0h, expected %0h", test_id, tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_byte", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic build(input int n, input int bad_at, input bit bad_hinib);
    logic [7:0] cs, op, hi;
    logic [3:0] hn, ln;
    prog.delete();
    prog.push_back(n[7:0]);
    cs = n[7:0];
    if (n == 0) return;
    for (int i = 0; i < n; i++) begin
      op = 8'($urandom);
      hi = 8'($urandom_range(0, 11));
      if (i == bad_at) begin
        hn = 4'($urandom_range(1, 15));
        ln = 4'($urandom_range(0, 15));
        hi = bad_hinib ? {hn, ln} : 8'($urandom_range(12, 15));
      end
      prog.push_back(op);
      prog.push_back(hi);
      cs = cs ^ op ^ hi;
      if (i == bad_at) return;
    end
`ifdef STACK_LOADER_CHECKSUM_EN
    prog.push_back((bad_at == n) ? ~cs : cs);
`endif
  endtask

  // Expected outcome of a byte program: words written in order, then zeros to 255.
  task automatic model();
    logic [7:0] cs, opb, hib;
    int n;
    for (int a = 0; a < 256; a++) exp_mem[a] = 12'hFFF;
    exp_err = 1'b0;
    exp_wl  = 0;
    n       = int'(prog[0]);
    exp_n   = n;
    cs      = prog[0];
    if (n == 0) exp_err = 1'b1;
    for (int i = 0; i < n && !exp_err; i++) begin
      opb = prog[1 + 2 * i];
      hib = prog[2 + 2 * i];
      if (hib > 8'd11) exp_err = 1'b1;
      else begin
        exp_mem[i] = {opb, hib[3:0]};
        exp_wl++;
      end
      cs = cs ^ opb ^ hib;
    end
`ifdef STACK_LOADER_CHECKSUM_EN
    if (!exp_err && prog[2 * n + 1] !== cs) exp_err = 1'b1;
`endif
    if (!exp_err) for (int a = n; a < 256; a++) exp_mem[a] = 12'h000;
    exp_wcnt = exp_err ? exp_wl : 256;
    if (!exp_err) exp_wl = n;
  endtask

  task automatic final_checks();
    int w, bad;
    w = 0;
    while (!(bus.run === 1'b1 || bus.error === 1'b1) && w < 600) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("run", 32'(bus.run), 32'(!exp_err));
    chk("error", 32'(bus.error), 32'(exp_err));
    chk("in_ready_end", 32'(bus.in_ready), 32'd0);
    chk("mem_we_end", 32'(bus.mem_we), 32'd0);
    chk("words_loaded", 32'(bus.words_loaded), 32'(exp_wl));
    chk("write_count", 32'(cap_cnt), 32'(exp_wcnt));
    bad = 0;
    for (int a = 0; a < 256; a++) if (cap_mem[a] !== exp_mem[a]) bad++;
    chk("mem_contents", 32'(bad), 32'd0);
    chk("monitor", 32'(mon_bad), 32'd0);
    if (!exp_err) chk("fill_span", cap_cyc[255] - cap_cyc[exp_n], 32'(255 - exp_n));
  endtask

  task automatic run_program(input bit with_reset, input int maxgap);
    if (with_reset) do_reset();
    model();
    foreach (prog[k]) send(prog[k], $urandom_range(0, maxgap));
    final_checks();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad_at, w;
    bit found;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    test_id = 1;
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_run", 32'(bus.run), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_words_loaded", 32'(bus.words_loaded), 32'd0);

    test_id = 2;
    prog = '{8'h02, 8'h0A, 8'h00, 8'h01, 8'h0B};
`ifdef STACK_LOADER_CHECKSUM_EN
    prog.push_back(8'h02);
`endif
    run_program(1'b1, 0);
    chk("word0", 32'(cap_mem[0]), 32'h0A0);
    chk("word1", 32'(cap_mem[1]), 32'h01B);
    chk("fill2", 32'(cap_mem[2]), 32'h000);
    chk("fill_254_cycles", cap_cyc[255] - cap_cyc[2], 32'd253);

    test_id = 3;
    do_reset();
    send(8'h00, 0);
    @(negedge clk);
    chk("len0_error", 32'(bus.error), 32'd1);
    chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
    chk("len0_run", 32'(bus.run), 32'd0);
    repeat (10) @(negedge clk);
    chk("len0_writes", 32'(cap_cnt), 32'd0);

    test_id = 4;
    prog = '{8'h01, 8'h05, 8'h0C};
    run_program(1'b1, 0);

    test_id = 5;
    prog = '{8'h01, 8'h05, 8'h1B};
    run_program(1'b1, 1);

    test_id = 6;
    prog = '{8'h02, 8'h05, 8'h0B, 8'h07, 8'h03};
`ifdef STACK_LOADER_CHECKSUM_EN
    prog.push_back(8'h08);
`endif
    do_reset();
    model();
    send(8'h02, 3);
    send(8'h05, 3);
    send(8'h0B, 3);
    @(negedge clk);
    chk("gap_we", 32'(bus.mem_we), 32'd1);
    chk("gap_addr", 32'(bus.mem_addr), 32'd0);
    chk("gap_wdata", 32'(bus.mem_wdata), 32'h05B);
    chk("gap_wl_during_write", 32'(bus.words_loaded), 32'd0);
    @(negedge clk);
    chk("gap_we_single", 32'(bus.mem_we), 32'd0);
    chk("gap_wl_after_write", 32'(bus.words_loaded), 32'd1);
    send(8'h07, 3);
    send(8'h03, 3);
`ifdef STACK_LOADER_CHECKSUM_EN
    send(8'h08, 3);
`endif
    final_checks();

`ifdef STACK_LOADER_CHECKSUM_EN
    test_id = 7;
    prog = '{8'h01, 8'h05, 8'h0B, 8'hFF};
    run_program(1'b1, 0);
    prog = '{8'h01, 8'h05, 8'h0B, 8'h0F};
    run_program(1'b1, 0);
`endif

    test_id = 8;
    do_reset();
    send(8'h02, 0);
    send(8'h05, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midword_we", 32'(bus.mem_we), 32'd0);
    chk("midword_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midword_no_write", 32'(cap_cnt), 32'd0);
    chk("midword_wl", 32'(bus.words_loaded), 32'd0);

    test_id = 9;
    prog = '{8'h01, 8'h05, 8'h0B};
`ifdef STACK_LOADER_CHECKSUM_EN
    prog.push_back(8'h0F);
`endif
    do_reset();
    foreach (prog[k]) send(prog[k], 0);
    found = 1'b0;
    w = 0;
    while (!found && w < 400) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1 && bus.mem_addr === 8'h40) found = 1'b1;
      w++;
    end
    chk("fill_reached_40", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midfill_we", 32'(bus.mem_we), 32'd0);
    chk("midfill_addr", 32'(bus.mem_addr), 32'd0);
    chk("midfill_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("midfill_run", 32'(bus.run), 32'd0);
    chk("midfill_error", 32'(bus.error), 32'd0);
    chk("midfill_wl", 32'(bus.words_loaded), 32'd0);
    chk("midfill_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    prog = '{8'h01, 8'h00, 8'h00};
`ifdef STACK_LOADER_CHECKSUM_EN
    prog.push_back(8'h01);
`endif
    run_program(1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      test_id = 10 + t;
      if (t == 0) n = 255;
      else if (t == 1) n = 1;
      else n = $urandom_range(2, 40);
      bad_at = (t % 3 == 2) ? int'($urandom_range(0, n - 1)) : -1;
`ifdef STACK_LOADER_CHECKSUM_EN
      if (t == 4) bad_at = n;
`endif
      build(n, bad_at, 1'($urandom_range(0, 1)));
      run_program(1'b1, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
